// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver and its in-flight queue.
package branch_pkg;
    // Queue entries are sized for the widest supported configuration; narrower
    // instances zero-extend on write and truncate on read.
    localparam int BR_MAX_XLEN  = 64;
    localparam int BR_MAX_IDX_W = 16;

    localparam logic [BR_MAX_XLEN-1:0] PC_INC = 64'd4;

    typedef struct packed {
        logic                    pred_taken;
        logic [BR_MAX_IDX_W-1:0] idx;
        logic [BR_MAX_XLEN-1:0]  pc;
        logic [BR_MAX_XLEN-1:0]  pred_target;
    } br_entry_t;
endpackage

// File: rtl/br_queue.sv
// In-order FIFO of predicted branches awaiting resolution, with a one-cycle clear.
module br_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      clear,
    input  logic      push,
    input  logic      pop,
    input  br_entry_t wdata,
    output br_entry_t rdata,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);

    br_entry_t      mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic           push_en, pop_en;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PW bits wide, so increment wraps modulo DEPTH.
            if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a write racing a clear is dropped with the entry.
    always_ff @(posedge clk) begin
        if (push_en && !clear && !reset) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/branch_resolver.sv
// Resolves queued branch predictions against execute outcomes, producing
// flush/redirect on mispredict and a training strobe for every resolve.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 6,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic             push_pred_taken,
    input  logic [IDX_W-1:0] push_idx,
    input  logic [XLEN-1:0]  push_pc,
    input  logic [XLEN-1:0]  push_pred_target,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_idx,
    output logic             upd_taken,
    output logic [31:0]      mispredict_count,
    output logic             underflow_err
);
    br_entry_t push_entry, head;
    logic      q_full, q_empty;
    logic      accept, mispredict;

    logic             flush_q, flush_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_taken_q, upd_taken_d;
    logic [31:0]      mispredict_count_q, mispredict_count_d;
    logic             underflow_err_q, underflow_err_d;

    always_comb begin
        push_entry             = '0;
        push_entry.pred_taken  = push_pred_taken;
        push_entry.idx         = BR_MAX_IDX_W'(push_idx);
        push_entry.pc          = BR_MAX_XLEN'(push_pc);
        push_entry.pred_target = BR_MAX_XLEN'(push_pred_target);
    end

    assign accept     = res_valid && !q_empty;
    assign mispredict = accept && ((head.pred_taken != res_taken) ||
                        (res_taken && (head.pred_target != BR_MAX_XLEN'(res_target))));
    assign push_ready = !q_full;

    br_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .reset (reset),
        .clear (mispredict),
        .push  (push_valid),
        .pop   (accept),
        .wdata (push_entry),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    always_comb begin
        flush_d            = mispredict;
        upd_valid_d        = accept;
        redirect_pc_d      = redirect_pc_q;
        upd_idx_d          = upd_idx_q;
        upd_taken_d        = upd_taken_q;
        mispredict_count_d = mispredict_count_q;
        underflow_err_d    = underflow_err_q || (res_valid && q_empty);
        if (accept) begin
            upd_idx_d   = IDX_W'(head.idx);
            upd_taken_d = res_taken;
        end
        if (mispredict) begin
            redirect_pc_d = res_taken ? res_target : XLEN'(head.pc + PC_INC);
            if (mispredict_count_q != '1) mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_q            <= 1'b0;
            redirect_pc_q      <= '0;
            upd_valid_q        <= 1'b0;
            upd_idx_q          <= '0;
            upd_taken_q        <= 1'b0;
            mispredict_count_q <= '0;
            underflow_err_q    <= 1'b0;
        end else begin
            flush_q            <= flush_d;
            redirect_pc_q      <= redirect_pc_d;
            upd_valid_q        <= upd_valid_d;
            upd_idx_q          <= upd_idx_d;
            upd_taken_q        <= upd_taken_d;
            mispredict_count_q <= mispredict_count_d;
            underflow_err_q    <= underflow_err_d;
        end
    end

    assign flush            = flush_q;
    assign redirect_pc      = redirect_pc_q;
    assign upd_valid        = upd_valid_q;
    assign upd_idx          = upd_idx_q;
    assign upd_taken        = upd_taken_q;
    assign mispredict_count = mispredict_count_q;
    assign underflow_err    = underflow_err_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Directed scenarios followed by random traffic, checked against a queue-based model.
module tb_branch_resolver;
    localparam int DEPTH = 4;
    localparam int IDX_W = 6;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             push_valid, push_ready, push_pred_taken;
    logic [IDX_W-1:0] push_idx;
    logic [XLEN-1:0]  push_pc, push_pred_target;
    logic             res_valid, res_taken;
    logic [XLEN-1:0]  res_target;
    logic             flush, upd_valid, upd_taken, underflow_err;
    logic [XLEN-1:0]  redirect_pc;
    logic [IDX_W-1:0] upd_idx;
    logic [31:0]      mispredict_count;

    branch_resolver #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_pred_taken  (push_pred_taken),
        .push_idx         (push_idx),
        .push_pc          (push_pc),
        .push_pred_target (push_pred_target),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .upd_valid        (upd_valid),
        .upd_idx          (upd_idx),
        .upd_taken        (upd_taken),
        .mispredict_count (mispredict_count),
        .underflow_err    (underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        pt;
        bit [5:0]  idx;
        bit [31:0] pc;
        bit [31:0] tgt;
    } ent_t;

    ent_t      mq[$];
    int        cmps = 0;
    int        errs = 0;
    bit        e_flush, e_upd, e_taken, e_und;
    bit [5:0]  e_idx;
    bit [31:0] e_redir, e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit pv, input bit pt, input bit [5:0] idx, input bit [31:0] pc,
                         input bit [31:0] tgt, input bit rv, input bit rt, input bit [31:0] rtgt,
                         input bit rst);
        push_valid = pv; push_pred_taken = pt; push_idx = idx; push_pc = pc;
        push_pred_target = tgt; res_valid = rv; res_taken = rt; res_target = rtgt; reset = rst;
    endtask

    // Apply the branch rules to the model for one edge, clock it, compare.
    task automatic cyc(input string tag);
        bit   ready_pre, mis, rst;
        ent_t h;
        #1;
        ready_pre = (mq.size() != DEPTH);
        chk({tag, ".push_ready"}, 32'(push_ready), 32'(ready_pre));
        rst = reset;
        e_flush = 0; e_upd = 0; mis = 0;
        if (rst) begin
            mq.delete();
            e_cnt = 0; e_und = 0; e_idx = 0; e_taken = 0; e_redir = 0;
        end else begin
            if (res_valid && mq.size() == 0) e_und = 1;
            if (res_valid && mq.size() > 0) begin
                h = mq.pop_front();
                e_upd = 1; e_idx = h.idx; e_taken = res_taken;
                mis = (h.pt != res_taken) || (res_taken && h.tgt != res_target);
                if (mis) begin
                    e_flush = 1;
                    if (e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 1;
                    e_redir = res_taken ? res_target : h.pc + 32'd4;
                    mq.delete();
                end
            end
            if (push_valid && ready_pre && !mis)
                mq.push_back('{push_pred_taken, push_idx, push_pc, push_pred_target});
        end
        @(posedge clk);
        #1;
        chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
        chk({tag, ".upd_valid"}, 32'(upd_valid), 32'(e_upd));
        chk({tag, ".mp_count"}, mispredict_count, e_cnt);
        chk({tag, ".underflow"}, 32'(underflow_err), 32'(e_und));
        chk({tag, ".count"}, 32'(dut.u_queue.count_q), 32'(mq.size()));
        if (e_upd || rst) begin
            chk({tag, ".upd_idx"}, 32'(upd_idx), 32'(e_idx));
            chk({tag, ".upd_taken"}, 32'(upd_taken), 32'(e_taken));
        end
        if (e_flush || rst) chk({tag, ".redirect"}, redirect_pc, e_redir);
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(tag);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("reset");
        idle("post_reset");

        // Correct taken prediction trains without flushing.
        drive(1, 1, 5, 32'h100, 32'h200, 0, 0, 0, 0); cyc("s39_push");
        drive(0, 0, 0, 0, 0, 1, 1, 32'h200, 0);        cyc("s39_res");
        chk("s39_idx", 32'(upd_idx), 32'd5);

        // Predicted not-taken, actually taken.
        drive(1, 0, 2, 32'h100, 32'h0, 0, 0, 0, 0);    cyc("s40_push");
        drive(0, 0, 0, 0, 0, 1, 1, 32'h180, 0);        cyc("s40_res");
        chk("s40_redirect", redirect_pc, 32'h180);

        // Predicted taken, actually not-taken: fall through to pc+4.
        drive(1, 1, 3, 32'h104, 32'h300, 0, 0, 0, 0);  cyc("s41_push");
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0, 0);          cyc("s41_res");
        chk("s41_redirect", redirect_pc, 32'h108);

        // Fill, overflow push, then mispredict with a concurrent push.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 6'(i + 8), 32'h400 + 32'(i * 4), 32'h200, 0, 0, 0, 0);
            cyc("s42_fill");
        end
        drive(1, 0, 1, 32'h500, 32'h0, 1, 1, 32'h444, 0); cyc("s42_mis_push");
        idle("s42_idle");

        // Resolve on an empty queue.
        drive(0, 0, 0, 0, 0, 1, 1, 32'h80, 0); cyc("s43_empty_res");
        idle("s43_sticky1");
        idle("s43_sticky2");

        // Build up seven mispredicts and three entries, then reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc("s44_pre_reset");
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 6'(i), 32'h600, 32'h0, 0, 0, 0, 0); cyc("s44_push");
            drive(0, 0, 0, 0, 0, 1, 1, 32'h700, 0);         cyc("s44_res");
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 6'(i), 32'h800, 32'h900, 0, 0, 0, 0); cyc("s44_fill");
        end
        chk("s44_cnt7", mispredict_count, 32'd7);
        drive(1, 1, 1, 32'h800, 32'h900, 1, 1, 32'h900, 1); cyc("s44_reset");
        chk("s44_ready", 32'(push_ready), 32'd1);

        // Random traffic with a small target set so hits and misses both occur.
        for (int n = 0; n < 800; n++) begin
            bit [31:0] pc;
            pc = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive(1'($urandom % 2), 1'($urandom % 2), 6'($urandom % 64), pc,
                  ($urandom % 2) ? 32'h200 : 32'h300,
                  1'(($urandom % 3) == 0), 1'($urandom % 2),
                  ($urandom % 2) ? 32'h200 : 32'h300,
                  1'(($urandom % 80) == 0));
            cyc("rand");
        end
        idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
